// File: rtl/otter_cu_fsm.sv
// Multicycle control unit for the OTTER RV32I core: sequences fetch, execute,
// load write-back and interrupt entry, one instruction per FETCH->EXEC(->WB) pass.
module otter_cu_fsm #(
  parameter int FETCH_LAT = 1
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [6:0] OPCODE,
  input  logic [2:0] FUNC3,
  input  logic       INTR,
  input  logic       CSR_MIE,
  output logic       RST,
  output logic       PC_WRITE,
  output logic       MEM_READ1,
  output logic       MEM_READ2,
  output logic       MEM_WE2,
  output logic       REG_WRITE,
  output logic       CSR_WE,
  output logic       INT_TAKEN,
  output logic       MRET_EXEC,
  output logic       ILLEGAL
);

  localparam logic [2:0] ST_INIT  = 3'd0;
  localparam logic [2:0] ST_FETCH = 3'd1;
  localparam logic [2:0] ST_EXEC  = 3'd2;
  localparam logic [2:0] ST_WB    = 3'd3;
  localparam logic [2:0] ST_INTR  = 3'd4;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_OPIMM  = 7'b0010011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [3:0] FETCH_LAST = 4'(FETCH_LAT - 1);

  logic [2:0] state;
  logic [2:0] state_nxt;
  logic [3:0] fetch_cnt;
  logic [3:0] fetch_cnt_nxt;
  logic       int_req;
  logic       is_load;

  assign int_req = INTR & CSR_MIE;
  assign is_load = (OPCODE == OP_LOAD);

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state     <= ST_INIT;
      fetch_cnt <= 4'd0;
    end else begin
      state     <= state_nxt;
      fetch_cnt <= fetch_cnt_nxt;
    end
  end

  // Interrupts are only examined at the instruction boundary (end of EXEC or WB).
  always_comb begin
    state_nxt     = state;
    fetch_cnt_nxt = fetch_cnt;
    case (state)
      ST_INIT: begin
        state_nxt     = ST_FETCH;
        fetch_cnt_nxt = 4'd0;
      end
      ST_FETCH: begin
        if (fetch_cnt == FETCH_LAST) begin
          fetch_cnt_nxt = 4'd0;
          state_nxt     = ST_EXEC;
        end else begin
          fetch_cnt_nxt = fetch_cnt + 4'd1;
        end
      end
      ST_EXEC: begin
        if (is_load)      state_nxt = ST_WB;
        else if (int_req) state_nxt = ST_INTR;
        else              state_nxt = ST_FETCH;
      end
      ST_WB:   state_nxt = int_req ? ST_INTR : ST_FETCH;
      ST_INTR: state_nxt = ST_FETCH;
      default: state_nxt = ST_INIT;
    endcase
  end

  always_comb begin
    RST       = 1'b0;
    PC_WRITE  = 1'b0;
    MEM_READ1 = 1'b0;
    MEM_READ2 = 1'b0;
    MEM_WE2   = 1'b0;
    REG_WRITE = 1'b0;
    CSR_WE    = 1'b0;
    INT_TAKEN = 1'b0;
    MRET_EXEC = 1'b0;
    ILLEGAL   = 1'b0;
    // The reset pin overrides decode directly so outputs drop without a clock.
    if (!RESET) begin
      RST = 1'b1;
    end else begin
      case (state)
        ST_INIT:  RST = 1'b1;
        ST_FETCH: MEM_READ1 = 1'b1;
        ST_EXEC: begin
          case (OPCODE)
            OP_LOAD:  MEM_READ2 = 1'b1;
            OP_STORE: begin
              MEM_WE2  = 1'b1;
              PC_WRITE = 1'b1;
            end
            OP_BRANCH: PC_WRITE = 1'b1;
            OP_JAL, OP_JALR, OP_LUI, OP_AUIPC, OP_OP, OP_OPIMM: begin
              PC_WRITE  = 1'b1;
              REG_WRITE = 1'b1;
            end
            OP_SYSTEM: begin
              PC_WRITE = 1'b1;
              if (FUNC3 == 3'b000) begin
                MRET_EXEC = 1'b1;
              end else begin
                CSR_WE    = 1'b1;
                REG_WRITE = 1'b1;
              end
            end
            default: begin
              ILLEGAL  = 1'b1;
              PC_WRITE = 1'b1;
            end
          endcase
        end
        ST_WB: begin
          REG_WRITE = 1'b1;
          PC_WRITE  = 1'b1;
        end
        ST_INTR: begin
          INT_TAKEN = 1'b1;
          PC_WRITE  = 1'b1;
        end
        default: RST = 1'b1;
      endcase
    end
  end

endmodule
